// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the single-issue MIPS datapath.
// Ports:
//   clk, rst (async, active-low)       clock and reset
//   opcode, funct, cp0_code            instruction register fields
//   zero, overflow                     ALU flags for the EXEC operands
//   int_request                        masked CP0 interrupt request
//   alu_ctl, ext_op, alu_src           ALU operation and operand select
//   reg_src, reg_dst, reg_write        GPR writeback source, target, enable
//   npc_sel, pc_write, rgs_ins_write   next-PC select, PC load, IR load
//   mem_write, mem_op                  DM write enable and access size
//   cp0_reg_write_en, exl_set, exl_clr CP0 controls
//   state                              current FSM state (debug)
module mc_ctrl #(
    parameter bit INT_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] cp0_code,
    input  logic       zero,
    input  logic       overflow,
    input  logic       int_request,
    output logic [1:0] alu_ctl,
    output logic       ext_op,
    output logic [2:0] reg_src,
    output logic [2:0] npc_sel,
    output logic [1:0] reg_dst,
    output logic       alu_src,
    output logic       mem_write,
    output logic       mem_op,
    output logic       reg_write,
    output logic       rgs_ins_write,
    output logic       pc_write,
    output logic       cp0_reg_write_en,
    output logic       exl_set,
    output logic       exl_clr,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        INT    = 3'd5
    } state_t;

    state_t state_q, state_d, fin;
    logic   ovf_q;

    logic r_type, cop0;
    logic i_addu, i_subu, i_slt, i_sra, i_jr, i_ori, i_addi, i_lw, i_lb, i_sw, i_sb, i_beq;
    logic i_j, i_jal, i_mtc0, i_mfc0, i_eret;
    logic ld, st, exec_cls;

    assign r_type   = opcode == 6'h00;
    assign cop0     = opcode == 6'h10;
    assign i_addu   = r_type && funct == 6'h21;
    assign i_subu   = r_type && funct == 6'h23;
    assign i_slt    = r_type && funct == 6'h2a;
    assign i_sra    = r_type && funct == 6'h03;
    assign i_jr     = r_type && funct == 6'h08;
    assign i_ori    = opcode == 6'h0d;
    assign i_addi   = opcode == 6'h08;
    assign i_lw     = opcode == 6'h23;
    assign i_lb     = opcode == 6'h20;
    assign i_sw     = opcode == 6'h2b;
    assign i_sb     = opcode == 6'h28;
    assign i_beq    = opcode == 6'h04;
    assign i_j      = opcode == 6'h02;
    assign i_jal    = opcode == 6'h03;
    assign i_mtc0   = cop0 && cp0_code == 5'b00100;
    assign i_mfc0   = cop0 && cp0_code == 5'b00000;
    assign i_eret   = cop0 && cp0_code == 5'b10000 && funct == 6'h18;
    assign ld       = i_lw || i_lb;
    assign st       = i_sw || i_sb;
    assign exec_cls = i_addu || i_subu || i_slt || i_sra || i_ori || i_addi || ld || st || i_beq;
    // Where an instruction goes after its final cycle (eret bypasses this).
    assign fin      = (INT_CHECK && int_request) ? INT : FETCH;
    assign state    = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Overflow is only valid while addi's operands are on the ALU.
            if (state_q == EXEC && i_addi) ovf_q <= overflow;
        end
    end

    always_comb begin
        state_d          = FETCH;
        alu_ctl          = 2'b00;
        ext_op           = 1'b0;
        reg_src          = 3'b000;
        npc_sel          = 3'b000;
        reg_dst          = 2'b00;
        alu_src          = 1'b0;
        mem_write        = 1'b0;
        mem_op           = 1'b0;
        reg_write        = 1'b0;
        rgs_ins_write    = 1'b0;
        pc_write         = 1'b0;
        cp0_reg_write_en = 1'b0;
        exl_set          = 1'b0;
        exl_clr          = 1'b0;
        case (state_q)
            FETCH: begin
                rgs_ins_write = 1'b1;
                pc_write      = 1'b1;
                state_d       = DECODE;
            end
            DECODE: begin
                pc_write         = i_j || i_jal || i_jr || i_eret;
                npc_sel          = (i_j || i_jal) ? 3'b010 : i_jr ? 3'b011 : i_eret ? 3'b100 : 3'b000;
                reg_write        = i_jal;
                reg_dst          = i_jal ? 2'b11 : 2'b00;
                reg_src          = i_jal ? 3'b100 : 3'b000;
                cp0_reg_write_en = i_mtc0;
                exl_clr          = i_eret;
                state_d          = i_eret ? FETCH : i_mfc0 ? WB : exec_cls ? EXEC : fin;
            end
            EXEC: begin
                alu_ctl  = (i_subu || i_beq) ? 2'b01 : i_slt ? 2'b11 : i_ori ? 2'b10 : 2'b00;
                alu_src  = i_ori || i_addi || ld || st;
                ext_op   = i_addi || ld || st;
                pc_write = i_beq && zero;
                npc_sel  = (i_beq && zero) ? 3'b001 : 3'b000;
                state_d  = i_beq ? fin : (ld || st) ? MEM : WB;
            end
            MEM: begin
                mem_write = st;
                mem_op    = i_lb || i_sb;
                state_d   = ld ? WB : fin;
            end
            WB: begin
                reg_write = 1'b1;
                reg_dst   = (ld || i_mfc0 || i_ori) ? 2'b01 : i_addi ? (ovf_q ? 2'b10 : 2'b01) : 2'b00;
                reg_src   = i_sra ? 3'b101 : ld ? 3'b001 : i_mfc0 ? 3'b110 : (i_addi && ovf_q) ? 3'b011 : 3'b000;
                state_d   = fin;
            end
            INT: begin
                exl_set  = 1'b1;
                pc_write = 1'b1;
                npc_sel  = 3'b101;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // No strobe may leak out while reset holds the machine.
        if (!rst) begin
            {alu_ctl, ext_op, reg_src, npc_sel, reg_dst, alu_src, mem_write, mem_op} = '0;
            {reg_write, rgs_ins_write, pc_write, cp0_reg_write_en, exl_set, exl_clr} = '0;
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and randomized checks of mc_ctrl against a per-instruction effect model.
module tb_mc_ctrl;
    logic       clk = 1'b0, rst = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic [4:0] cp0_code = '0;
    logic       zero = 1'b0, overflow = 1'b0, int_request = 1'b0;

    logic [1:0] alu_ctl, reg_dst, z_alu_ctl, z_reg_dst;
    logic [2:0] reg_src, npc_sel, state, z_reg_src, z_npc_sel, z_state;
    logic       ext_op, alu_src, mem_write, mem_op, reg_write, rgs_ins_write, pc_write;
    logic       cp0_reg_write_en, exl_set, exl_clr;
    logic       z_ext_op, z_alu_src, z_mem_write, z_mem_op, z_reg_write, z_rgs_ins_write, z_pc_write;
    logic       z_cp0_reg_write_en, z_exl_set, z_exl_clr;
    logic [22:0] all_o, z_all;

    int  n_chk = 0, n_fail = 0;
    bit  sync0 = 1'b1;

    localparam int C_ADDU = 0, C_SUBU = 1, C_SLT = 2, C_SRA = 3, C_ORI = 4, C_ADDI = 5;
    localparam int C_LW = 6, C_LB = 7, C_SW = 8, C_SB = 9, C_BEQ = 10, C_J = 11, C_JAL = 12;
    localparam int C_JR = 13, C_MTC0 = 14, C_MFC0 = 15, C_ERET = 16, C_NOP = 17;

    mc_ctrl #(.INT_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .cp0_code(cp0_code),
        .zero(zero), .overflow(overflow), .int_request(int_request),
        .alu_ctl(alu_ctl), .ext_op(ext_op), .reg_src(reg_src), .npc_sel(npc_sel),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_write(mem_write), .mem_op(mem_op),
        .reg_write(reg_write), .rgs_ins_write(rgs_ins_write), .pc_write(pc_write),
        .cp0_reg_write_en(cp0_reg_write_en), .exl_set(exl_set), .exl_clr(exl_clr), .state(state)
    );

    mc_ctrl #(.INT_CHECK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .cp0_code(cp0_code),
        .zero(zero), .overflow(overflow), .int_request(int_request),
        .alu_ctl(z_alu_ctl), .ext_op(z_ext_op), .reg_src(z_reg_src), .npc_sel(z_npc_sel),
        .reg_dst(z_reg_dst), .alu_src(z_alu_src), .mem_write(z_mem_write), .mem_op(z_mem_op),
        .reg_write(z_reg_write), .rgs_ins_write(z_rgs_ins_write), .pc_write(z_pc_write),
        .cp0_reg_write_en(z_cp0_reg_write_en), .exl_set(z_exl_set), .exl_clr(z_exl_clr), .state(z_state)
    );

    assign all_o = {alu_ctl, ext_op, reg_src, npc_sel, reg_dst, alu_src, mem_write, mem_op,
                    reg_write, rgs_ins_write, pc_write, cp0_reg_write_en, exl_set, exl_clr, state};
    assign z_all = {z_alu_ctl, z_ext_op, z_reg_src, z_npc_sel, z_reg_dst, z_alu_src, z_mem_write, z_mem_op,
                    z_reg_write, z_rgs_ins_write, z_pc_write, z_cp0_reg_write_en, z_exl_set, z_exl_clr, z_state};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input int c);
        funct    = 6'($urandom);
        cp0_code = 5'($urandom);
        case (c)
            C_ADDU: {opcode, funct} = {6'h00, 6'h21};
            C_SUBU: {opcode, funct} = {6'h00, 6'h23};
            C_SLT:  {opcode, funct} = {6'h00, 6'h2a};
            C_SRA:  {opcode, funct} = {6'h00, 6'h03};
            C_JR:   {opcode, funct} = {6'h00, 6'h08};
            C_ORI:  opcode = 6'h0d;
            C_ADDI: opcode = 6'h08;
            C_LW:   opcode = 6'h23;
            C_LB:   opcode = 6'h20;
            C_SW:   opcode = 6'h2b;
            C_SB:   opcode = 6'h28;
            C_BEQ:  opcode = 6'h04;
            C_J:    opcode = 6'h02;
            C_JAL:  opcode = 6'h03;
            C_MTC0: {opcode, cp0_code} = {6'h10, 5'b00100};
            C_MFC0: {opcode, cp0_code} = {6'h10, 5'b00000};
            C_ERET: {opcode, cp0_code, funct} = {6'h10, 5'b10000, 6'h18};
            default: {opcode, funct} = $urandom_range(0, 1) ? {6'h3f, funct} : {6'h00, 6'h00};
        endcase
    endtask

    // Runs one instruction from FETCH and checks its architectural effects:
    // state trace, one-shot writes, and the control values at each write.
    task automatic run(input int c, input bit z, input bit ov, input bit irq);
        int  exp_s[$];
        int  base_len, nir = 0, nrw = 0, nmw = 0, npw = 0, ncp = 0, nset = 0, nclr = 0;
        int  e_rw, e_pw, e_dst, e_src, e_npc, e_ctl, e_asrc, e_ext;
        bit  took, has_exec, br_pc;
        logic [1:0] rdst = 'x, actl = 'x;
        logic [2:0] rsrc = 'x, npc = 'x, npc_int = 'x;
        logic       mop = 'x, asrc = 'x, eop = 'x;
        if (c inside {C_ADDU, C_SUBU, C_SLT, C_SRA, C_ORI, C_ADDI}) exp_s = '{0, 1, 2, 4};
        else if (c inside {C_LW, C_LB}) exp_s = '{0, 1, 2, 3, 4};
        else if (c inside {C_SW, C_SB}) exp_s = '{0, 1, 2, 3};
        else if (c == C_BEQ) exp_s = '{0, 1, 2};
        else if (c == C_MFC0) exp_s = '{0, 1, 4};
        else exp_s = '{0, 1};
        base_len = exp_s.size();
        took = irq && c != C_ERET;
        if (took) exp_s.push_back(5);
        set_instr(c);
        for (int i = 0; i < exp_s.size(); i++) begin
            zero        = (exp_s[i] == 2) ? z : 1'($urandom);
            overflow    = (exp_s[i] == 2) ? ov : 1'($urandom);
            int_request = (i == base_len - 1) ? irq : 1'($urandom);
            #1;
            chk("state", state, exp_s[i]);
            if (sync0) begin
                chk("nocheck_state", z_state, i < base_len ? exp_s[i] : 0);
                chk("nocheck_exl_set", z_exl_set, 0);
            end
            if (exp_s[i] == 0) chk("fetch_npc", npc_sel, 0);
            nir  += rgs_ins_write;
            nset += exl_set;
            nclr += exl_clr;
            ncp  += cp0_reg_write_en;
            if (reg_write) begin nrw++; rdst = reg_dst; rsrc = reg_src; end
            if (mem_write) begin nmw++; mop = mem_op; end
            if (pc_write) begin
                npw++;
                if (exp_s[i] == 5) npc_int = npc_sel;
                else if (exp_s[i] != 0) npc = npc_sel;
            end
            if (exp_s[i] == 2) begin actl = alu_ctl; asrc = alu_src; eop = ext_op; end
            @(posedge clk);
            #1;
        end
        e_rw  = c inside {C_ADDU, C_SUBU, C_SLT, C_SRA, C_ORI, C_ADDI, C_LW, C_LB, C_JAL, C_MFC0};
        br_pc = c inside {C_J, C_JAL, C_JR, C_ERET} || (c == C_BEQ && z);
        e_pw  = 1 + br_pc + took;
        e_npc = (c == C_J || c == C_JAL) ? 2 : c == C_JR ? 3 : c == C_ERET ? 4 : 1;
        chk("ir_load_count", nir, 1);
        chk("reg_write_count", nrw, e_rw);
        chk("mem_write_count", nmw, c inside {C_SW, C_SB});
        chk("pc_write_count", npw, e_pw);
        chk("cp0_write_count", ncp, c == C_MTC0);
        chk("exl_clr_count", nclr, c == C_ERET);
        chk("exl_set_count", nset, took);
        if (took) chk("int_npc", npc_int, 5);
        if (br_pc) chk("branch_npc", npc, e_npc);
        if (c inside {C_SW, C_SB}) chk("mem_op", mop, c == C_SB);
        if (e_rw) begin
            case (c)
                C_SRA:        {e_dst, e_src} = {32'd0, 32'd5};
                C_ORI:        {e_dst, e_src} = {32'd1, 32'd0};
                C_ADDI:       {e_dst, e_src} = ov ? {32'd2, 32'd3} : {32'd1, 32'd0};
                C_LW, C_LB:   {e_dst, e_src} = {32'd1, 32'd1};
                C_JAL:        {e_dst, e_src} = {32'd3, 32'd4};
                C_MFC0:       {e_dst, e_src} = {32'd1, 32'd6};
                default:      {e_dst, e_src} = {32'd0, 32'd0};
            endcase
            chk("wb_reg_dst", rdst, e_dst);
            chk("wb_reg_src", rsrc, e_src);
        end
        has_exec = c inside {C_ADDU, C_SUBU, C_SLT, C_ORI, C_ADDI, C_LW, C_LB, C_SW, C_SB, C_BEQ};
        if (has_exec) begin
            e_ctl  = c == C_SUBU || c == C_BEQ ? 1 : c == C_SLT ? 3 : c == C_ORI ? 2 : 0;
            e_asrc = c inside {C_ORI, C_ADDI, C_LW, C_LB, C_SW, C_SB};
            e_ext  = c inside {C_ADDI, C_LW, C_LB, C_SW, C_SB};
            chk("exec_alu_ctl", actl, e_ctl);
            chk("exec_alu_src", asrc, e_asrc);
            if (e_asrc) chk("exec_ext_op", eop, e_ext);
        end
        if (took) sync0 = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        opcode = 6'h00;
        funct = 6'h21;
        #12;
        chk("reset_outputs", all_o, 0);
        chk("reset_outputs_nocheck", z_all, 0);
        #10;
        rst = 1'b1;
        run(C_ADDU, 1'b0, 1'b0, 1'b0);
        run(C_LW, 1'b0, 1'b0, 1'b0);
        run(C_BEQ, 1'b1, 1'b0, 1'b0);
        run(C_BEQ, 1'b0, 1'b0, 1'b0);
        run(C_ADDI, 1'b0, 1'b1, 1'b0);
        run(C_ADDI, 1'b0, 1'b0, 1'b0);
        run(C_SW, 1'b0, 1'b0, 1'b1);
        run(C_ERET, 1'b0, 1'b0, 1'b1);
        set_instr(C_ADDU);
        int_request = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_abort_state", state, 2);
        rst = 1'b0;
        #1;
        chk("abort_outputs", all_o, 0);
        chk("abort_state", state, 0);
        @(posedge clk);
        #1;
        chk("held_reset_outputs", all_o, 0);
        rst = 1'b1;
        sync0 = 1'b1;
        for (int k = 0; k < 60; k++)
            run($urandom_range(0, 17), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
